nanov_uart_rx: RTL and testbench

Receive-side UART for the nanoV Tiny Tapeout top, the counterpart of the existing transmitter. Sits between the `uio_in[5]` pad (RX line) and the CPU's memory-mapped read path. Deserialises 8N1 frames, validates start and stop bits, and buffers received bytes until the CPU pops them. Error conditions are reported through sticky flags.

---
 rtl/nanov_uart_pkg.sv | 22 ++
 rtl/nanov_rx_fifo.sv | 92 +++++++++
 rtl/nanov_uart_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_nanov_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_uart_pkg.sv
// ----------------------------------------------------------------------------
// nanov_uart_pkg
//
// Shared definitions for the nanoV UART blocks.
//   uart_rx_state_t : receiver FSM states (IDLE, START, DATA, STOP, BREAK)
//   cycles_per_bit  : integer clocks per UART bit, shared with the transmitter
// ----------------------------------------------------------------------------
package nanov_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/nanov_rx_fifo.sv
// ----------------------------------------------------------------------------
// nanov_rx_fifo
//
// Synchronous first-word-fall-through circular buffer for received bytes.
// The head entry is visible on rdata whenever valid is high; a pop advances
// the head on the next clock edge.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset (empties the buffer)
//   push     in   write wdata this cycle
//   wdata    in   byte to store
//   pop      in   advance the head (ignored when empty)
//   rdata    out  head entry, 0 while empty
//   valid    out  buffer non-empty
//   overflow out  single-cycle pulse: push refused because the buffer is full
// ----------------------------------------------------------------------------
module nanov_rx_fifo
    import nanov_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic full;
    logic pop_ok;
    logic push_ok;

    always_comb begin
        full     = (cnt_q == DEPTH_C);
        pop_ok   = pop && (cnt_q != '0);
        // A pop in the same cycle frees the slot, so a full buffer can still
        // accept the incoming byte.
        push_ok  = push && (!full || pop_ok);
        overflow = push && full && !pop_ok;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign valid = (cnt_q != '0);
    assign rdata = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/nanov_uart_rx.sv
// ----------------------------------------------------------------------------
// nanov_uart_rx
//
// 8N1 UART receiver for the nanoV top. Synchronises the RX pad, samples each
// bit mid-period, validates start/stop bits and buffers received bytes for
// the CPU load path. Errors are reported through sticky flags.
//
// Build option: define NANOV_UART_RX_FIFO_EN to buffer FIFO_DEPTH bytes in a
// circular FIFO; otherwise a single holding register plus valid bit is used.
//
// Ports:
//   clk       in   system clock, posedge
//   rst_n     in   synchronous active-low reset
//   uart_rxd  in   asynchronous RX line, idle high
//   rd_en     in   pop the head byte (ignored when empty)
//   clr_err   in   clear frame_err and overrun (a same-cycle new error wins)
//   rx_data   out  head byte, first-word fall-through
//   rx_valid  out  buffer non-empty
//   frame_err out  sticky: stop bit sampled low
//   overrun   out  sticky: byte dropped because the buffer was full
// ----------------------------------------------------------------------------
module nanov_uart_rx
    import nanov_uart_pkg::*;
#(
    parameter int CLK_HZ     = 20_000_000,
    parameter int BIT_RATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser; both stages reset to the idle (high) level so
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_rx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_push;
    logic             frame_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_push = 1'b0;
        frame_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (cnt_q == CNT_MID) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave for IDLE in the sample cycle so a start bit that
                // follows immediately is not missed.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        byte_push = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must not be decoded as a stream of frames.
                cnt_d = '0;
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    logic buf_overflow;

`ifdef NANOV_UART_RX_FIFO_EN
    nanov_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (byte_push),
        .wdata    (shift_q),
        .pop      (rd_en),
        .rdata    (rx_data),
        .valid    (rx_valid),
        .overflow (buf_overflow)
    );
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    always_comb begin
        hold_d       = hold_q;
        valid_d      = valid_q;
        buf_overflow = 1'b0;
        if (byte_push && valid_q && !rd_en) begin
            // Keep the unread byte; the new one is lost.
            buf_overflow = 1'b1;
        end else begin
            if (rd_en) begin
                valid_d = 1'b0;
            end
            if (byte_push) begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = valid_q;
`endif

    // ------------------------------------------------------------------
    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    always_comb begin
        frame_err_d = (frame_err_q && !clr_err) || frame_set;
        overrun_d   = (overrun_q && !clr_err) || buf_overflow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_nanov_uart_rx.sv
`timescale 1ns/1ps
module tb_nanov_uart_rx;

    localparam int CPB  = 173;
    localparam int HALF = 86;
    localparam int LAT  = 1646;
`ifdef NANOV_UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rd_en    = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] exp_q [$];

    typedef struct packed {
        logic [7:0] data;
        logic       stop_ok;
    } vec_t;

    vec_t vecs [6];

    nanov_uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge once the stop bit has ended.
    // Bytes expected to be buffered are queued as the frame starts.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic accept);
        if (stop_bit && accept) exp_q.push_back(b);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pop_expect(input string name);
        logic [7:0] exp;
        int waited;
        waited = 0;
        while (!rx_valid && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s valid", name), rx_valid, 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("%s data", name), rx_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        logic got;

        vecs[0] = '{data: 8'h00, stop_ok: 1'b1};
        vecs[1] = '{data: 8'hFF, stop_ok: 1'b1};
        vecs[2] = '{data: 8'h55, stop_ok: 1'b1};
        vecs[3] = '{data: 8'h3C, stop_ok: 1'b0};
        vecs[4] = '{data: 8'h11, stop_ok: 1'b1};
        vecs[5] = '{data: 8'h80, stop_ok: 1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // Single frame with push latency measurement
        lat = cyc;
        w   = 0;
        got = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                while (!rx_valid && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                got = rx_valid;
                lat = cyc - lat;
            end
        join
        check("A5 arrived", got, 1);
        n_total++;
        if (lat >= LAT - 1 && lat <= LAT + 1) begin
            n_pass++;
            $display("ok   latency: %0d cycles", lat);
        end else begin
            $display("FAIL latency: got %0d cycles required %0d..%0d", lat, LAT - 1, LAT + 1);
        end
        pop_expect("A5");
        check("A5 drained", rx_valid, 0);

        // Table of single frames, including one with a low stop bit
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, 1'b1);
            if (vecs[i].stop_ok) begin
                pop_expect($sformatf("vec%0d", i));
                check($sformatf("vec%0d drained", i), rx_valid, 0);
                check($sformatf("vec%0d frame_err", i), frame_err, 0);
            end else begin
                repeat (2000) @(negedge clk);
                check($sformatf("vec%0d frame_err set", i), frame_err, 1);
                check($sformatf("vec%0d no push", i), rx_valid, 0);
                uart_rxd = 1'b1;
                repeat (20) @(negedge clk);
                check($sformatf("vec%0d no frame from break", i), rx_valid, 0);
                pulse_clr();
                check($sformatf("vec%0d frame_err cleared", i), frame_err, 0);
            end
            repeat (10) @(negedge clk);
        end

        // Glitch rejection, then a good frame proves the FSM is back in IDLE
        uart_rxd = 1'b0;
        repeat (40) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch no push", rx_valid, 0);
        check("glitch no frame_err", frame_err, 0);
        send_frame(8'hC3, 1'b1, 1'b1);
        pop_expect("after glitch");

        // Overrun: one more frame than the buffer holds, no reads
        for (int i = 1; i <= CAP + 1; i++) begin
            if (i == CAP + 1) check("overrun before extra", overrun, 0);
            send_frame(8'(i), 1'b1, (i <= CAP));
        end
        check("overrun set", overrun, 1);
        for (int i = 0; i < CAP; i++) pop_expect($sformatf("ovr pop%0d", i));
        check("ovr drained", rx_valid, 0);
        pulse_clr();
        check("overrun cleared", overrun, 0);
        repeat (10) @(negedge clk);

        // Full buffer with a pop in the push cycle of 8'h77
        for (int i = 1; i <= CAP; i++) send_frame(8'(i), 1'b1, 1'b1);
        fork
            send_frame(8'h77, 1'b1, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                check("simul head", rx_data, exp_q[0]);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                void'(exp_q.pop_front());
            end
        join
        check("simul no overrun", overrun, 0);
        for (int i = 0; i < CAP; i++) pop_expect($sformatf("simul pop%0d", i));
        check("simul drained", rx_valid, 0);
        repeat (10) @(negedge clk);

        // Reset during bit 4 with bytes buffered
        send_frame(8'hAA, 1'b1, 1'b1);
        send_frame(8'hBB, 1'b1, 1'b1);
        uart_rxd = 1'b0;
        repeat (CPB * 5 + HALF) @(negedge clk);
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst rx_valid", rx_valid, 0);
        check("midrst rx_data", rx_data, 8'h00);
        check("midrst frame_err", frame_err, 0);
        check("midrst overrun", overrun, 0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        pop_expect("5A after reset");
        check("5A drained", rx_valid, 0);
        check("5A frame_err", frame_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
